text_scroll_encoder: RTL and testbench
======================================

Name: text_scroll_encoder

Overview:
- Produces the 18-bit one-hot letter codes consumed by the board's letter-code-to-7-segment decoder, one digit at a time.
- Accepts an ASCII message over a valid/ready write port into an internal buffer.
- Time-multiplexes four display digits through active-low anodes.
- Optionally scrolls the message across the four-digit window.

Parameters:
- MSG_LEN, 16: message buffer depth in characters. Must be a power of 2 and at least 4.
- REFRESH_DIV, 100000: clock cycles per digit-select step.
- SCROLL_DIV, 25000000: clock cycles per scroll step.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_valid  in  1  write request
- wr_data  in  8  ASCII character
- wr_ready  out  1  write accepted when wr_valid && wr_ready at a rising clk edge
- clear  in  1  synchronous message flush
- scroll_en  in  1  enable scrolling
- digit_code  out  18  letter code for the active digit
- anode  out  4  active-low digit enable; bit 3 is the leftmost digit
- msg_len  out  $clog2(MSG_LEN)+1  number of stored characters

Behaviour:
- Reset values: msg_len=0, offset=0, refresh counter=0, scroll counter=0, digit select=0, anode=4'b1110, digit_code=18'b11 (blank), wr_ready=0 during reset.
- Write port:
  - wr_ready = (msg_len < MSG_LEN) && !clear.
  - An accepted write stores wr_data at index msg_len, increments msg_len, and zeroes offset and the scroll counter.
  - When full, wr_ready=0; wr_valid is ignored and no overwrite occurs.
- clear (one cycle): msg_len=0, offset=0, scroll counter=0. clear wins over a same-cycle write, which is not accepted.
- Encoding (case-insensitive ASCII):
  - A→bit17, B→16, C→15, D→14, E→13, F→12, G→11, H→10, I and '1'→9, L→8, N→7, O and '0'→6, P→5, R→4, S→3, U and V→2, Y→1, Z→0.
  - '3'→18'b111.
  - Space and every other character→18'b11 (blank).
- Digit multiplexing:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, digit select d advances 0→1→2→3→0.
  - anode = ~(4'b1 << d).
  - anode and digit_code are both registered from the same next-state, so they change on the same edge and are never skewed.
- Window content: digit d shows position p = offset + (3-d).
  - If msg_len <= 4: p < msg_len → encoded char, otherwise blank.
  - If msg_len > 4: p is taken modulo msg_len (wrap-around).
- Scroll FSM states:
  - EMPTY: msg_len=0. All digits blank; counters still run.
  - STATIC: 1 <= msg_len <= 4, or scroll_en=0. offset holds its value.
  - SCROLL: msg_len > 4 and scroll_en=1. The scroll counter counts 0..SCROLL_DIV-1; on wrap, offset = (offset+1 == msg_len) ? 0 : offset+1.
- Transitions are evaluated every cycle from msg_len and scroll_en.
  - Dropping scroll_en freezes offset; it does not reset it.
  - A write or clear resets offset to 0 in any state.
- Latency: a stored character appears on its digit at the next selection of that digit, at most 4*REFRESH_DIV cycles later. digit_code lags internal state by 1 register stage.
- Asynchronous reset mid-scroll returns every register to its reset value immediately. The message contents are not guaranteed, but msg_len=0, so they are never displayed.

Decomposition:
- Package text_codes_pkg:
  - 18-bit localparams CODE_A..CODE_Z, CODE_3=18'b111, CODE_BLANK=18'b11.
  - DIGITS=4.
  - Scroll FSM state enum {EMPTY, STATIC, SCROLL}.
- Sub-module ascii_to_letter_code: purely combinational, 8-bit ASCII in, 18-bit code out. Instantiated once on the buffer read port for the selected digit.

Test Plan (REFRESH_DIV=4, SCROLL_DIV=64, MSG_LEN=16):
- Reset asserted mid-operation → anode=4'b1110, digit_code=18'b11 and msg_len=0 in the same cycle; wr_ready=0 until reset deasserts.
- Write "HI" with scroll_en=0, then observe 16 cycles →
  - anode=0111: digit_code=18'h00400 (H)
  - anode=1011: 18'h00200 (I)
  - anode=1101 and 1110: 18'b11
  - each digit held exactly 4 cycles.
- Write "hello3" with scroll_en=1 →
  - Initially digits 3..0 = H,E,L,L.
  - After 64 cycles: E,L,L,O.
  - After 128 cycles: L,L,O,'3' (18'b111).
  - After 384 cycles: wraps to H,E,L,L.
- Write 16 chars, then hold wr_valid high with a 17th → wr_ready=0, msg_len stays 16, buffer unchanged.
- Same-cycle clear=1 and wr_valid=1 → write not accepted, msg_len=0, all digits blank, FSM in EMPTY.
- Write "X#z" → X and '#' display 18'b11; 'z' displays 18'h00001.

Source files
------------

// File: rtl/text_codes_pkg.sv
// Letter-code constants for the one-hot 7-segment letter decoder, plus shared
// display constants and the scroll FSM state type.
package text_codes_pkg;

    localparam int DIGITS = 4;

    localparam logic [17:0] CODE_A     = 18'h20000;
    localparam logic [17:0] CODE_B     = 18'h10000;
    localparam logic [17:0] CODE_C     = 18'h08000;
    localparam logic [17:0] CODE_D     = 18'h04000;
    localparam logic [17:0] CODE_E     = 18'h02000;
    localparam logic [17:0] CODE_F     = 18'h01000;
    localparam logic [17:0] CODE_G     = 18'h00800;
    localparam logic [17:0] CODE_H     = 18'h00400;
    localparam logic [17:0] CODE_I     = 18'h00200;
    localparam logic [17:0] CODE_L     = 18'h00100;
    localparam logic [17:0] CODE_N     = 18'h00080;
    localparam logic [17:0] CODE_O     = 18'h00040;
    localparam logic [17:0] CODE_P     = 18'h00020;
    localparam logic [17:0] CODE_R     = 18'h00010;
    localparam logic [17:0] CODE_S     = 18'h00008;
    localparam logic [17:0] CODE_U     = 18'h00004;
    localparam logic [17:0] CODE_V     = 18'h00004;
    localparam logic [17:0] CODE_Y     = 18'h00002;
    localparam logic [17:0] CODE_Z     = 18'h00001;
    localparam logic [17:0] CODE_3     = 18'b111;
    localparam logic [17:0] CODE_BLANK = 18'b11;

    typedef enum logic [1:0] {
        EMPTY,
        STATIC,
        SCROLL
    } scroll_state_e;

endpackage

// File: rtl/ascii_to_letter_code.sv
// Case-insensitive ASCII to 18-bit one-hot letter code; anything the decoder
// cannot draw maps to blank.
module ascii_to_letter_code
    import text_codes_pkg::*;
(
    input  logic [7:0]  ascii_i,
    output logic [17:0] code_o
);

    logic [7:0] upper;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        upper  = ascii_i;
        code_o = CODE_BLANK;
        if (ascii_i >= "a" && ascii_i <= "z") begin
            upper = ascii_i - 8'h20;
        end
        case (upper)
            "A":      code_o = CODE_A;
            "B":      code_o = CODE_B;
            "C":      code_o = CODE_C;
            "D":      code_o = CODE_D;
            "E":      code_o = CODE_E;
            "F":      code_o = CODE_F;
            "G":      code_o = CODE_G;
            "H":      code_o = CODE_H;
            "I", "1": code_o = CODE_I;
            "L":      code_o = CODE_L;
            "N":      code_o = CODE_N;
            "O", "0": code_o = CODE_O;
            "P":      code_o = CODE_P;
            "R":      code_o = CODE_R;
            "S":      code_o = CODE_S;
            "U":      code_o = CODE_U;
            "V":      code_o = CODE_V;
            "Y":      code_o = CODE_Y;
            "Z":      code_o = CODE_Z;
            "3":      code_o = CODE_3;
            default:  code_o = CODE_BLANK;
        endcase
    end

endmodule

// File: rtl/text_scroll_encoder.sv
// Message buffer, four-digit multiplexer and scroll controller driving the
// board's letter-code decoder one digit at a time.
module text_scroll_encoder
    import text_codes_pkg::*;
#(
    parameter int MSG_LEN     = 16,
    parameter int REFRESH_DIV = 100000,
    parameter int SCROLL_DIV  = 25000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [7:0]                 wr_data,
    output logic                       wr_ready,
    input  logic                       clear,
    input  logic                       scroll_en,
    output logic [17:0]                digit_code,
    output logic [3:0]                 anode,
    output logic [$clog2(MSG_LEN):0]   msg_len
);

    localparam int IW = $clog2(MSG_LEN);
    localparam int LW = IW + 1;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(SCROLL_DIV);

    logic [7:0]    mem_q [MSG_LEN];
    logic [LW-1:0] len_q, len_d;
    logic [IW-1:0] offset_q, offset_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    anode_q, anode_d;
    logic [17:0]   code_q, code_d;
    scroll_state_e state_q, state_d;

    logic          wr_fire;
    logic [LW-1:0] pos;
    logic [LW-1:0] idx;
    logic          pos_valid;
    logic [17:0]   dec_code;

    assign wr_ready = !reset && (len_q < LW'(MSG_LEN)) && !clear;
    assign wr_fire  = wr_valid && wr_ready;

    always_comb begin
        state_d = STATIC;
        if (len_d == '0) begin
            state_d = EMPTY;
        end else if (len_d > LW'(DIGITS) && scroll_en) begin
            state_d = SCROLL;
        end
    end

    // clear beats a write, a write beats a scroll step; both restart the window at 0.
    always_comb begin
        len_d    = len_q;
        offset_d = offset_q;
        scnt_d   = scnt_q;
        if (clear) begin
            len_d    = '0;
            offset_d = '0;
            scnt_d   = '0;
        end else if (wr_fire) begin
            len_d    = len_q + LW'(1);
            offset_d = '0;
            scnt_d   = '0;
        end else if (state_q == SCROLL) begin
            if (scnt_q == SW'(SCROLL_DIV - 1)) begin
                scnt_d   = '0;
                offset_d = ({1'b0, offset_q} + LW'(1) == len_q) ? '0 : offset_q + IW'(1);
            end else begin
                scnt_d = scnt_q + SW'(1);
            end
        end
    end

    always_comb begin
        rcnt_d = rcnt_q + RW'(1);
        sel_d  = sel_q;
        if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
            rcnt_d = '0;
            sel_d  = sel_q + 2'd1;
        end
    end

    // offset < len and 3 < len when wrapping, so a single subtract is a full modulo.
    always_comb begin
        pos       = {1'b0, offset_q} + LW'(2'd3 - sel_q);
        idx       = pos;
        pos_valid = 1'b1;
        if (len_q <= LW'(DIGITS)) begin
            pos_valid = (pos < len_q);
        end else if (pos >= len_q) begin
            idx = pos - len_q;
        end
    end

    ascii_to_letter_code u_decode (
        .ascii_i (mem_q[idx[IW-1:0]]),
        .code_o  (dec_code)
    );

    always_comb begin
        anode_d = ~(4'b0001 << sel_q);
        code_d  = pos_valid ? dec_code : CODE_BLANK;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q    <= '0;
            offset_q <= '0;
            rcnt_q   <= '0;
            scnt_q   <= '0;
            sel_q    <= '0;
            state_q  <= EMPTY;
            anode_q  <= 4'b1110;
            code_q   <= CODE_BLANK;
        end else begin
            len_q    <= len_d;
            offset_q <= offset_d;
            rcnt_q   <= rcnt_d;
            scnt_q   <= scnt_d;
            sel_q    <= sel_d;
            state_q  <= state_d;
            anode_q  <= anode_d;
            code_q   <= code_d;
        end
    end

    // NOTE: the buffer has no reset; msg_len=0 after reset keeps stale entries from ever showing.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[len_q[IW-1:0]] <= wr_data;
        end
    end

    assign digit_code = code_q;
    assign anode      = anode_q;
    assign msg_len    = len_q;

endmodule

// File: tb/tb_text_scroll_encoder.sv
// Scoreboard bench: stimulus pushes expected (anode, code) pairs, a monitor
// matches each against the digit the DUT presents.
module tb_text_scroll_encoder;

    localparam int MSG_LEN     = 16;
    localparam int REFRESH_DIV = 4;
    localparam int SCROLL_DIV  = 64;

    localparam logic [17:0] C_A  = 18'h20000;
    localparam logic [17:0] C_B  = 18'h10000;
    localparam logic [17:0] C_C  = 18'h08000;
    localparam logic [17:0] C_D  = 18'h04000;
    localparam logic [17:0] C_E  = 18'h02000;
    localparam logic [17:0] C_H  = 18'h00400;
    localparam logic [17:0] C_I  = 18'h00200;
    localparam logic [17:0] C_L  = 18'h00100;
    localparam logic [17:0] C_O  = 18'h00040;
    localparam logic [17:0] C_Z  = 18'h00001;
    localparam logic [17:0] C_3  = 18'h00007;
    localparam logic [17:0] C_BL = 18'h00003;

    typedef struct packed {
        logic [3:0]  anode;
        logic [17:0] code;
        logic [15:0] id;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_ready;
    logic        clear = 1'b0;
    logic        scroll_en = 1'b0;
    logic [17:0] digit_code;
    logic [3:0]  anode;
    logic [4:0]  msg_len;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    text_scroll_encoder #(
        .MSG_LEN     (MSG_LEN),
        .REFRESH_DIV (REFRESH_DIV),
        .SCROLL_DIV  (SCROLL_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .clear      (clear),
        .scroll_en  (scroll_en),
        .digit_code (digit_code),
        .anode      (anode),
        .msg_len    (msg_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_window(input logic [15:0] id, input logic [17:0] c3, input logic [17:0] c2,
                               input logic [17:0] c1, input logic [17:0] c0);
        exp_q.push_back('{anode: 4'b0111, code: c3, id: id});
        exp_q.push_back('{anode: 4'b1011, code: c2, id: id});
        exp_q.push_back('{anode: 4'b1101, code: c1, id: id});
        exp_q.push_back('{anode: 4'b1110, code: c0, id: id});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left after %0d cycles", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic write_char(input logic [7:0] c);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = c;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic write_str(input string s);
        for (int i = 0; i < s.len(); i++) write_char(s[i]);
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: the DUT "presents" a digit when its anode is active.
    initial begin
        exp_t e;
        int   waited;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                waited = 0;
                while (anode !== e.anode && waited < 40) begin
                    @(negedge clk);
                    waited++;
                end
                n_checks++;
                if (anode !== e.anode) begin
                    n_fail++;
                    $display("FAIL window%0d: anode %b never seen, last anode %b", e.id, e.anode, anode);
                end else if (digit_code !== e.code) begin
                    n_fail++;
                    $display("FAIL window%0d anode %b: code got %h expected %h", e.id, e.anode,
                             digit_code, e.code);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int t0;
        int run;
        int n;

        // Reset values
        #1 reset = 1'b1;
        #1;
        check("rst_anode", 32'(anode), 32'h0000000e);
        check("rst_code", 32'(digit_code), 32'(C_BL));
        check("rst_len", 32'(msg_len), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 check("ready_after_rst", 32'(wr_ready), 32'd1);

        // "HI", static
        scroll_en = 1'b0;
        write_str("HI");
        settle();
        check("hi_len", 32'(msg_len), 32'd2);
        push_window(16'd1, C_H, C_I, C_BL, C_BL);
        drain();

        n = 0;
        while (anode === 4'b0111 && n < 40) begin @(negedge clk); n++; end
        while (anode !== 4'b0111 && n < 40) begin @(negedge clk); n++; end
        run = 0;
        while (anode === 4'b0111 && run < 40) begin @(negedge clk); run++; end
        check("digit_hold_cycles", 32'(run), 32'd4);

        // "hello3", scrolling
        clear_pulse();
        check("clear_len", 32'(msg_len), 32'd0);
        scroll_en = 1'b1;
        write_str("hello3");
        t0 = cyc;
        check("hello_len", 32'(msg_len), 32'd6);
        wait_until(t0 + 2);
        push_window(16'd2, C_H, C_E, C_L, C_L);
        drain();
        wait_until(t0 + SCROLL_DIV + 2);
        push_window(16'd3, C_E, C_L, C_L, C_O);
        drain();
        wait_until(t0 + 2 * SCROLL_DIV + 2);
        push_window(16'd4, C_L, C_L, C_O, C_3);
        drain();
        wait_until(t0 + 5 * SCROLL_DIV + 2);
        push_window(16'd5, C_3, C_H, C_E, C_L);
        drain();
        wait_until(t0 + 6 * SCROLL_DIV + 2);
        push_window(16'd6, C_H, C_E, C_L, C_L);
        drain();

        // Asynchronous reset mid-scroll
        wait_until(t0 + 6 * SCROLL_DIV + 40);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = "A";
        #2 reset = 1'b1;
        #1;
        check("mid_rst_anode", 32'(anode), 32'h0000000e);
        check("mid_rst_code", 32'(digit_code), 32'(C_BL));
        check("mid_rst_len", 32'(msg_len), 32'd0);
        check("mid_rst_ready", 32'(wr_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("mid_rst_ready_hold", 32'(wr_ready), 32'd0);
        check("mid_rst_len_hold", 32'(msg_len), 32'd0);
        wr_valid = 1'b0;
        reset = 1'b0;
        #1 check("ready_after_mid_rst", 32'(wr_ready), 32'd1);

        // Fill to 16, then a held 17th write
        scroll_en = 1'b0;
        write_str("ABCDEFGHIJKLMNOP");
        check("full_len", 32'(msg_len), 32'd16);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = "Z";
        #1 check("full_ready", 32'(wr_ready), 32'd0);
        repeat (3) @(negedge clk);
        wr_valid = 1'b0;
        check("full_len_hold", 32'(msg_len), 32'd16);
        settle();
        push_window(16'd7, C_A, C_B, C_C, C_D);
        drain();

        // clear and write in the same cycle
        clear_pulse();
        write_str("AB");
        check("ab_len", 32'(msg_len), 32'd2);
        @(negedge clk);
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = "C";
        #1 check("clear_wr_ready", 32'(wr_ready), 32'd0);
        @(negedge clk);
        clear    = 1'b0;
        wr_valid = 1'b0;
        check("clear_wr_len", 32'(msg_len), 32'd0);
        settle();
        push_window(16'd8, C_BL, C_BL, C_BL, C_BL);
        drain();

        // Unsupported characters and lowercase
        write_str("X#z");
        settle();
        check("xz_len", 32'(msg_len), 32'd3);
        push_window(16'd9, C_BL, C_BL, C_Z, C_BL);
        drain();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
